mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 256-bit data-memory interface between the instruction cache (port 0) and the data cache (port 1). It sits between both cache controllers' memory-side ports and the data memory. It grants one requester at a time, holds the grant until the memory acknowledges, and steers the ack back to the granted port only.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise port 1 always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] win_o
);

  logic tie_pick1;

`ifdef MEM_ARB_RR_EN
  // The port that was not granted last wins a tie.
  assign tie_pick1 = ~last_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign tie_pick1   = 1'b1;
`endif

  always_comb begin
    win_o = GRANT_NONE;
    if (req0_i && req1_i) begin
      win_o = tie_pick1 ? GRANT_P1 : GRANT_P0;
    end else if (req0_i) begin
      win_o = GRANT_P0;
    end else if (req1_i) begin
      win_o = GRANT_P1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one line-wide memory between I-cache (port 0) and D-cache (port 1).
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break instead of fixed port-1 priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  arb_state_e state_q, state_d;
  logic       last_gnt;
  logic [1:0] win;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // Only a completed transfer updates the history; an abort leaves it alone.
  always_comb begin
    last_d = last_q;
    if (mem_ack_i && (state_q == GNT0)) last_d = 1'b0;
    if (mem_ack_i && (state_q == GNT1)) last_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b1;
`endif

  mem_arb_pick u_pick (
    .req0_i (m0_enable_i),
    .req1_i (m1_enable_i),
    .last_i (last_gnt),
    .win_o  (win)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Every grant returns through IDLE, giving the requester one cycle to drop its enable.
  always_comb begin
    state_d      = state_q;
    grant_o      = GRANT_NONE;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win == GRANT_P0)      state_d = GNT0;
        else if (win == GRANT_P1) state_d = GNT1;
      end
      GNT0: begin
        grant_o      = GRANT_P0;
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
        if (mem_ack_i || !m0_enable_i) state_d = IDLE;
      end
      GNT1: begin
        grant_o      = GRANT_P1;
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
        if (mem_ack_i || !m1_enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random phase,
// all compared cycle by cycle against a transaction-level ownership model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [1:0] en, wr;
  logic [1:0][AW-1:0] ad;
  logic [1:0][DW-1:0] dt;
  logic [DW-1:0] m0_data_o, m1_data_o, mem_data_o, mdata;
  logic m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, busy_o, mack;
  logic [AW-1:0] mem_addr_o;
  logic [1:0] grant_o;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns memory, who completed last, how long the owner has held it.
  logic own_v, own_p, last_p;
  int   gcnt, lat, cyc;
  logic auto_mem, rnd_mode;
  logic [1:0] keep, rearm, ackd, prev_grant;
  int   gp[$];
  int   gc[$];
  int   ack_cnt0, ack_cnt1;

  always #5 clk_i = ~clk_i;

  mem_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_enable_i  (en[0]),
    .m0_write_i   (wr[0]),
    .m0_addr_i    (ad[0]),
    .m0_data_i    (dt[0]),
    .m0_data_o    (m0_data_o),
    .m0_ack_o     (m0_ack_o),
    .m1_enable_i  (en[1]),
    .m1_write_i   (wr[1]),
    .m1_addr_i    (ad[1]),
    .m1_data_i    (dt[1]),
    .m1_data_o    (m1_data_o),
    .m1_ack_o     (m1_ack_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mdata),
    .mem_ack_i    (mack),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic tie_winner();
`ifdef MEM_ARB_RR_EN
    return ~last_p;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_outputs();
    logic [1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ee, ew;
    eg = GRANT_NONE; ee = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (own_v) begin
      eg = own_p ? GRANT_P1 : GRANT_P0;
      ee = en[own_p]; ew = wr[own_p]; ea = ad[own_p]; ed = dt[own_p];
    end
    chk("grant", DW'(grant_o), DW'(eg));
    chk("busy", DW'(busy_o), DW'(own_v));
    chk("mem_en", DW'(mem_enable_o), DW'(ee));
    chk("mem_wr", DW'(mem_write_o), DW'(ew));
    chk("mem_addr", DW'(mem_addr_o), DW'(ea));
    chk("mem_wdata", mem_data_o, ed);
    chk("ack0", DW'(m0_ack_o), DW'(own_v && !own_p && mack));
    chk("ack1", DW'(m1_ack_o), DW'(own_v && own_p && mack));
    if (own_v) chk("rdata", own_p ? m1_data_o : m0_data_o, mdata);
    if (m0_ack_o) ack_cnt0++;
    if (m1_ack_o) ack_cnt1++;
    if (grant_o != 2'b00 && prev_grant == 2'b00) begin
      gp.push_back(int'(grant_o[1]));
      gc.push_back(cyc);
    end
    prev_grant = grant_o;
  endtask

  task automatic model_update();
    ackd = 2'b00;
    if (!rst_i) begin
      own_v = 1'b0; last_p = 1'b1; gcnt = 0;
    end else if (!own_v) begin
      if (en != 2'b00) begin
        own_v = 1'b1;
        own_p = (en == 2'b11) ? tie_winner() : en[1];
        gcnt  = 1;
      end
    end else if (mack) begin
      ackd[own_p] = 1'b1; last_p = own_p; own_v = 1'b0; gcnt = 0;
    end else if (!en[own_p]) begin
      own_v = 1'b0; gcnt = 0;
    end else begin
      gcnt++;
    end
    cyc++;
  endtask

  // Plays both cache controllers and the memory for the next cycle.
  task automatic drive_next();
    for (int x = 0; x < 2; x++) begin
      if (ackd[x]) begin
        en[x] = 1'b0; rearm[x] = keep[x];
      end else if (rearm[x]) begin
        en[x] = 1'b1; rearm[x] = 1'b0;
      end
    end
    mack  = auto_mem && own_v && (gcnt >= lat);
    mdata = rnd_line();
    if (rnd_mode) begin
      for (int x = 0; x < 2; x++) begin
        if (!en[x] && !ackd[x] && $urandom_range(2) == 0) begin
          en[x] = 1'b1;
          wr[x] = 1'($urandom_range(1));
          ad[x] = $urandom() & 32'hFFFF_FFE0;
          dt[x] = rnd_line();
        end else if (en[x] && $urandom_range(19) == 0) begin
          en[x] = 1'b0;
        end
      end
      mack = ($urandom_range(3) == 0);
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    drive_next();
  endtask

  task automatic run_idle(input string tag, input int bound);
    int  n;
    bit  done;
    n = 0;
    done = !(own_v || en != 2'b00 || rearm != 2'b00);
    while (!done && n < bound) begin
      step();
      n++;
      done = !(own_v || en != 2'b00 || rearm != 2'b00);
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL %s timeout observed=%0d cycles expected=idle", tag, n);
    end
  endtask

  task automatic clear_log();
    gp.delete(); gc.delete();
    ack_cnt0 = 0; ack_cnt1 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    logic first;
    logic [DW-1:0] pat;

    rst_i = 1'b0; en = '0; wr = '0; ad = '0; dt = '0; mdata = '0; mack = 1'b0;
    own_v = 1'b0; own_p = 1'b0; last_p = 1'b1; gcnt = 0; lat = 1; cyc = 0;
    auto_mem = 1'b0; rnd_mode = 1'b0; keep = '0; rearm = '0; ackd = '0; prev_grant = '0;
    clear_log();

    // Reset state, including requests and a stray ack held during reset.
    @(negedge clk_i);
    en = 2'b11; mack = 1'b1;
    step();
    en = 2'b00; mack = 1'b0;
    step();
    rst_i = 1'b1;
    step();

    // Single port-1 read at 0x400, memory answers after 10 cycles.
    clear_log();
    ad[1] = 32'h0000_0400; wr[1] = 1'b0; dt[1] = rnd_line();
    en[1] = 1'b1; auto_mem = 1'b1; lat = 10; t0 = cyc;
    run_idle("t1_done", 40);
    chk("t1_ngrant", DW'(gp.size()), DW'(1));
    chk("t1_port", DW'(gp.size() > 0 ? gp[0] : -1), DW'(1));
    chk("t1_latency", DW'(gc.size() > 0 ? gc[0] - t0 : -1), DW'(1));
    chk("t1_ack1_count", DW'(ack_cnt1), DW'(1));
    chk("t1_ack0_count", DW'(ack_cnt0), DW'(0));

    // Simultaneous first requests: tie rule, then one bubble, then the other port.
    clear_log();
    ad[0] = 32'h0000_1000; ad[1] = 32'h0000_2000; wr = 2'b00;
    en = 2'b11; lat = 3; t0 = cyc; first = tie_winner();
    run_idle("t2_done", 40);
    chk("t2_ngrant", DW'(gp.size()), DW'(2));
    chk("t2_first", DW'(gp.size() > 0 ? gp[0] : -1), DW'(first));
    chk("t2_second", DW'(gp.size() > 1 ? gp[1] : -1), DW'(!first));
    chk("t2_latency", DW'(gc.size() > 0 ? gc[0] - t0 : -1), DW'(1));
    chk("t2_gap", DW'(gc.size() > 1 ? gc[1] - gc[0] : -1), DW'(lat + 1));

    // Continuous contention for six transactions.
    clear_log();
    keep = 2'b11; en = 2'b11; lat = 2; first = tie_winner();
    for (int n = 0; n < 100 && gp.size() < 6; n++) step();
    keep = 2'b00;
    run_idle("t3_drain", 40);
    chk("t3_ngrant_min", DW'(gp.size() >= 6), DW'(1));
    for (int i = 0; i < 6 && i < gp.size(); i++) begin
      chk("t3_order", DW'(gp[i]), DW'(first ^ 1'(i & 1)));
      if (i > 0) chk("t3_gap", DW'(gc[i] - gc[i-1]), DW'(lat + 1));
    end

    // Port-1 write-back while port 0 waits.
    clear_log();
    pat = {32{8'hA5}};
    ad[1] = 32'h0000_8000; wr[1] = 1'b1; dt[1] = pat; en[1] = 1'b1; lat = 5;
    step();
    ad[0] = 32'h0000_0040; wr[0] = 1'b0; en[0] = 1'b1;
    #1;
    chk("t4_write", DW'(mem_write_o), DW'(1));
    chk("t4_wdata", mem_data_o, pat);
    chk("t4_no_ack0", DW'(m0_ack_o), DW'(0));
    run_idle("t4_done", 40);
    chk("t4_order0", DW'(gp.size() > 0 ? gp[0] : -1), DW'(1));
    chk("t4_order1", DW'(gp.size() > 1 ? gp[1] : -1), DW'(0));

    // Abort in GNT0, then a stray ack in IDLE.
    clear_log();
    auto_mem = 1'b0; ad[0] = 32'h0000_0100; en[0] = 1'b1;
    step();
    step();
    en[0] = 1'b0;
    step();
    #1;
    chk("t5_busy", DW'(busy_o), DW'(0));
    chk("t5_mem_en", DW'(mem_enable_o), DW'(0));
    mack = 1'b1;
    #1;
    chk("t5_stray_ack0", DW'(m0_ack_o), DW'(0));
    chk("t5_stray_ack1", DW'(m1_ack_o), DW'(0));
    step();
    mack = 1'b0;
    step();

    // Reset asserted mid-GNT1, then normal recovery.
    ad[1] = 32'h0000_4000; en[1] = 1'b1;
    step();
    step();
    chk("t6_pre_busy", DW'(busy_o), DW'(1));
    rst_i = 1'b0;
    #1;
    chk("t6_grant", DW'(grant_o), DW'(0));
    chk("t6_busy", DW'(busy_o), DW'(0));
    chk("t6_mem_en", DW'(mem_enable_o), DW'(0));
    chk("t6_mem_addr", DW'(mem_addr_o), DW'(0));
    chk("t6_ack1", DW'(m1_ack_o), DW'(0));
    own_v = 1'b0; last_p = 1'b1; gcnt = 0; en = 2'b00; mack = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    clear_log();
    ad[0] = 32'h0000_0200; en[0] = 1'b1; auto_mem = 1'b1; lat = 2; t0 = cyc;
    run_idle("t6_done", 40);
    chk("t6_port", DW'(gp.size() > 0 ? gp[0] : -1), DW'(0));
    chk("t6_latency", DW'(gc.size() > 0 ? gc[0] - t0 : -1), DW'(1));

    // Random traffic with aborts and stray acks.
    auto_mem = 1'b0; rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) step();
    rnd_mode = 1'b0; en = 2'b00; mack = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
